// File: rtl/fifo_stream_reader_pkg.sv
// Shared FIFO parameter defaults, imported by blocks that sit beside the FIFO top.
package fifo_stream_reader_pkg;

  localparam int unsigned FifoWidth = 8;

endpackage

// File: rtl/fifo_stream_reader.sv
// Converts a FIFO read port with one-cycle read latency into a valid/ready stream
// through a two-entry skid buffer, sustaining one word per cycle.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH     = FifoWidth,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_read_req,
  input  logic [WIDTH-1:0] ram_read_data,
  input  logic             flush,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_data
);

  if (BUF_DEPTH != 2) begin : g_bad_depth
    $error("fifo_stream_reader supports BUF_DEPTH == 2 only");
  end

  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic             head_q, head_d;
  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [WIDTH-1:0] buf_d [BUF_DEPTH];

  logic       pop;
  logic       wr_en;
  logic       tail;
  logic [2:0] committed;

  assign dout_valid = (occ_q != 2'd0);
  assign dout_data  = buf_q[head_q];
  assign pop        = dout_valid & dout_ready;
  assign wr_en      = inflight_q & ~flush;
  // With two entries, head + occ wraps so a full buffer writes the slot being popped.
  assign tail       = head_q ^ occ_q[0];
  assign committed  = {1'b0, occ_q} + {2'b00, inflight_q};

  // Combinational from dout_ready so a draining buffer can refill every cycle.
  assign fifo_read_req = rst_n & ~fifo_empty & ~flush & (committed <= 3'd1 + {2'b00, pop});

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    buf_d  = buf_q;
    if (pop) begin
      head_d = ~head_q;
    end
    if (wr_en) begin
      buf_d[tail] = ram_read_data;
    end
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      occ_d = occ_q + {1'b0, wr_en} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= 1'b0;
      buf_q      <= '{default: '0};
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_read_req;
      head_q     <= head_d;
      buf_q      <= buf_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_en && occ_q == 2'd2 && !pop));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized and directed bench for fifo_stream_reader against a queue-based model.
module tb_fifo_stream_reader;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_read_req;
  logic [W-1:0] ram_read_data;
  logic         flush;
  logic         dout_valid;
  logic         dout_ready;
  logic [W-1:0] dout_data;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .WIDTH    (W),
    .BUF_DEPTH(2)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_read_req(fifo_read_req),
    .ram_read_data(ram_read_data),
    .flush        (flush),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .dout_data    (dout_data)
  );

  // A word the reader has claimed from the FIFO; landed once its data has been captured.
  typedef struct packed {
    logic [W-1:0] d;
    logic         landed;
  } ent_t;

  ent_t         pend[$];
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] got_q[$];
  logic [W-1:0] next_word;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cnt, valid_cnt, pop_cnt, first_req, first_valid, first_pop, last_pop;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    req_cnt = 0; valid_cnt = 0; pop_cnt = 0;
    first_req = -1; first_valid = -1; first_pop = -1; last_pop = -1;
    got_q.delete();
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      push_word(next_word);
      next_word = next_word + 8'd1;
    end
  endtask

  // Check at the falling edge, then advance the model to just after the rising edge.
  task automatic step();
    bit   exp_valid, exp_pop, exp_req, req_s;
    int   sz;
    ent_t e;
    exp_pop = 1'b0;
    @(negedge clk);
    req_s = fifo_read_req;
    if (!rst_n) begin
      check("rst_valid", int'(dout_valid), 0);
      check("rst_req", int'(req_s), 0);
      check("rst_data", int'(dout_data), 0);
    end else begin
      sz        = pend.size();
      exp_valid = (sz > 0) && pend[0].landed;
      check("valid", int'(dout_valid), int'(exp_valid));
      if (exp_valid) check("data", int'(dout_data), int'(pend[0].d));
      exp_pop = exp_valid && dout_ready;
      exp_req = (fifo_q.size() != 0) && !flush && (sz - int'(exp_pop) <= 1);
      check("req", int'(req_s), int'(exp_req));
      if (req_s) begin
        req_cnt++;
        if (first_req < 0) first_req = cyc;
      end
      if (dout_valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (exp_pop) begin
        got_q.push_back(pend[0].d);
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    ram_read_data = W'($urandom);
    if (rst_n) begin
      if (exp_pop) void'(pend.pop_front());
      if (flush) pend.delete();
      else foreach (pend[i]) pend[i].landed = 1'b1;
      if (req_s && fifo_q.size() > 0) begin
        e.d      = fifo_q.pop_front();
        e.landed = 1'b0;
        pend.push_back(e);
        ram_read_data = e.d;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [W-1:0] first_w;
    rst_n         = 1'b0;
    flush         = 1'b0;
    dout_ready    = 1'b0;
    fifo_empty    = 1'b1;
    ram_read_data = '0;
    next_word     = 8'h40;
    clear_stats();

    // Reset holds everything quiet even with a loaded FIFO.
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    dout_ready = 1'b1;
    run(3);
    rst_n = 1'b1;
    cyc   = 1;
    clear_stats();
    run(8);
    check("t1_first_req_cyc", first_req, 1);
    check("t1_first_valid_cyc", first_valid, 3);
    check("t1_req_cnt", req_cnt, 3);
    check("t1_valid_cnt", valid_cnt, 3);
    check("t1_got_cnt", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t1_w0", int'(got_q[0]), 'h11);
      check("t1_w1", int'(got_q[1]), 'h22);
      check("t1_w2", int'(got_q[2]), 'h33);
    end

    // Continuous 16-word stream: back-to-back delivery.
    clear_stats();
    load(16);
    run(22);
    check("t2_pop_cnt", pop_cnt, 16);
    check("t2_no_gaps", last_pop - first_pop, 15);
    check("t2_fill", first_pop - first_req, 2);

    // Stall with 5 words: only two reads, head held.
    clear_stats();
    dout_ready = 1'b0;
    first_w    = next_word;
    load(5);
    run(6);
    check("t3_req_cnt", req_cnt, 2);
    check("t3_valid", int'(dout_valid), 1);
    check("t3_head", int'(dout_data), int'(first_w));
    run(3);
    check("t3_stable", int'(dout_data), int'(first_w));
    dout_ready = 1'b1;
    run(8);
    check("t3_pop_cnt", pop_cnt, 5);

    // Alternating ready over 8 words.
    clear_stats();
    load(8);
    for (int i = 0; i < 24; i++) begin
      dout_ready = (i % 2 == 0);
      step();
    end
    dout_ready = 1'b1;
    run(4);
    check("t4_pop_cnt", pop_cnt, 8);

    // Flush with a full buffer, then flush while a read is in flight.
    clear_stats();
    dout_ready = 1'b0;
    load(6);
    run(5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_valid", int'(dout_valid), 0);
    dout_ready = 1'b1;
    run(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush2_valid", int'(dout_valid), 0);
    run(8);
    check("t5_drained", fifo_q.size() + pend.size(), 0);

    // Asynchronous reset mid-stream.
    load(10);
    run(4);
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", int'(dout_valid), 0);
    check("t6_async_req", int'(fifo_read_req), 0);
    check("t6_async_data", int'(dout_data), 0);
    pend.delete();
    run(2);
    rst_n = 1'b1;
    clear_stats();
    run(12);
    check("t6_restart_pops", pop_cnt > 0 ? 1 : 0, 1);
    check("t6_drained", fifo_q.size() + pend.size(), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      dout_ready = ($urandom % 4) != 0;
      flush      = ($urandom % 25) == 0;
      if (($urandom % 3) == 0 && fifo_q.size() < 20) load(int'($urandom_range(1, 3)));
      step();
    end
    flush      = 1'b0;
    dout_ready = 1'b1;
    for (int i = 0; i < 60 && (fifo_q.size() + pend.size()) != 0; i++) step();
    check("rand_drained", fifo_q.size() + pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the data word width.
REQ-002 The module SHALL have parameter BUF_DEPTH, fixed at 2, giving the output buffer entries; other values are unsupported.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port fifo_empty, input, 1 bit: FIFO empty flag from the FIFO read side.
REQ-006 Port fifo_read_req, output, 1 bit: pop request to the FIFO, one word per asserted cycle.
REQ-007 Port ram_read_data, input, WIDTH bits: FIFO read data, valid exactly one cycle after fifo_read_req.
REQ-008 Port flush, input, 1 bit: synchronous discard of buffered and in-flight words.
REQ-009 Port dout_valid, output, 1 bit: dout_data holds a word.
REQ-010 Port dout_ready, input, 1 bit: downstream accepts the word.
REQ-011 Port dout_data, output, WIDTH bits: head word of the output buffer.

Function
REQ-012 A transfer SHALL occur on every cycle with dout_valid and dout_ready both high ("pop").
REQ-013 State SHALL be: occ (0..2, buffer occupancy), inflight (1 bit, read issued last cycle), and a 2-entry buffer with head pointer.
REQ-014 fifo_read_req SHALL be high when all of these hold: !fifo_empty, !flush, and (occ + inflight - pop) <= 1.
REQ-015 This combinational path from dout_ready to fifo_read_req SHALL be kept, so steady-state throughput is one word per cycle.
REQ-016 inflight SHALL take the value of fifo_read_req at each clock edge.
REQ-017 When inflight is high and flush is low, ram_read_data SHALL be written into the buffer tail that cycle.
REQ-018 A same-cycle write and pop SHALL both take effect: occ unchanged, head advanced, tail written.
REQ-019 The buffer SHALL never overflow.
REQ-020 A write while occ==2 and no pop is a design error; assertion-checked.
REQ-021 dout_valid SHALL equal (occ != 0).
REQ-022 dout_data SHALL equal the head entry.
REQ-023 dout_data SHALL be stable while dout_valid is high and dout_ready is low.
REQ-024 Words SHALL be delivered in FIFO order, with no loss or duplication absent flush.
REQ-025 Latency from first fifo_read_req (FIFO non-empty, buffer empty) to dout_valid SHALL be 2 cycles: request in cycle N, data captured at the end of N+1, dout_valid in N+2.
REQ-026 When fifo_empty is high, no read SHALL be issued; buffered words still drain.
REQ-027 The head pointer SHALL wrap 1->0 on pop.
REQ-028 flush high SHALL, at the next edge, set occ=0 and inflight=0, and discard any in-flight ram_read_data.
REQ-029 While flush is high, dout_valid SHALL still reflect current occ, and a pop that cycle SHALL be legal.

Reset
REQ-030 rst_n low SHALL immediately clear occ, inflight, head pointer, and buffer contents to 0.
REQ-031 While rst_n is low, fifo_read_req SHALL be 0, dout_valid 0, and dout_data 0.
REQ-032 Reset mid-operation SHALL drop in-flight data.
REQ-033 The first read after reset SHALL be issued no earlier than the first cycle after rst_n deasserts.

Structure
REQ-034 WIDTH SHALL default identically to the FIFO top's WIDTH, taken from the team's shared FIFO parameter defaults.
REQ-035 No new shared typedefs or constants SHALL be required.
REQ-036 The block SHALL be a single module with no sub-module.
REQ-037 The block SHALL be instantiable beside the FIFO top, with fifo_empty, fifo_read_req and ram_read_data wired directly.

Verification
REQ-038 Reset then load FIFO with 0x11,0x22,0x33; dout_ready=1 -> fifo_read_req in cycles 1-3, dout_valid cycles 3-5, data 0x11,0x22,0x33, then dout_valid=0.
REQ-039 Continuous stream of 16 words, dout_ready=1 -> one word per cycle after 2-cycle fill, no gaps, order preserved.
REQ-040 FIFO holds 5 words, dout_ready=0 -> exactly 2 reads issued, occ=2, dout_data=first word, stable; release ready -> remaining 3 delivered in order.
REQ-041 Toggle dout_ready 1,0,1,0 on 8-word stream -> no loss or duplication, fifo_read_req never makes occ+inflight exceed 2.
REQ-042 Assert flush for 1 cycle with occ=2, inflight=1 -> next cycle dout_valid=0, in-flight word discarded, later reads resume with the next FIFO word.
REQ-043 Drop rst_n mid-stream (occ=1, inflight=1) -> dout_valid and fifo_read_req go 0 immediately, without waiting for clk; after release, reading restarts cleanly.
